// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time on every edge of pwm_in.
// Pulses shorter than the dead time are swallowed. Switching starts only from a low input after en.
module pwm_deadtime #(
   parameter int DT_WIDTH = 6
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                pwm_in,
   input  logic                en,
   input  logic                dt_wr,
   input  logic [DT_WIDTH-1:0] dead_time_in,
   output logic                out_hi,
   output logic                out_lo,
   output logic                dt_busy
);

   localparam logic [2:0] S_OFF     = 3'd0;
   localparam logic [2:0] S_LO_ON   = 3'd1;
   localparam logic [2:0] S_DT_RISE = 3'd2;
   localparam logic [2:0] S_HI_ON   = 3'd3;
   localparam logic [2:0] S_DT_FALL = 3'd4;

   localparam logic [DT_WIDTH-1:0] DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]          state_q, state_d;
   logic [DT_WIDTH-1:0] dt_q, dt_d;
   logic [DT_WIDTH-1:0] cnt_q, cnt_d;
   logic                lock_q, lock_d;
   logic                hi_q, hi_d;
   logic                lo_q, lo_d;
   logic                busy_q, busy_d;

   // Dead-time register: one capture per dt_wr high period, zero clamps to one cycle.
   always_comb begin
      dt_d   = dt_q;
      lock_d = dt_wr;
      if (dt_wr && !lock_q) begin
         dt_d = (dead_time_in == '0) ? DT_ONE : dead_time_in;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en) begin
         state_d = S_OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               if (!pwm_in) state_d = S_LO_ON;
            end
            S_LO_ON: begin
               if (pwm_in) begin
                  state_d = S_DT_RISE;
                  cnt_d   = dt_q;
               end
            end
            S_DT_RISE: begin
               if (!pwm_in)             state_d = S_LO_ON;
               else if (cnt_q > DT_ONE) cnt_d   = cnt_q - DT_ONE;
               else                     state_d = S_HI_ON;
            end
            S_HI_ON: begin
               if (!pwm_in) begin
                  state_d = S_DT_FALL;
                  cnt_d   = dt_q;
               end
            end
            S_DT_FALL: begin
               if (pwm_in)              state_d = S_HI_ON;
               else if (cnt_q > DT_ONE) cnt_d   = cnt_q - DT_ONE;
               else                     state_d = S_LO_ON;
            end
            default: state_d = S_OFF;
         endcase
      end
   end

   // Outputs decode the next state so they are registered yet switch on the deciding edge.
   always_comb begin
      hi_d   = (state_d == S_HI_ON);
      lo_d   = (state_d == S_LO_ON);
      busy_d = (state_d == S_DT_RISE) || (state_d == S_DT_FALL);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OFF;
         dt_q    <= DT_ONE;
         cnt_q   <= '0;
         lock_q  <= 1'b0;
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dt_q    <= dt_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   assign out_hi  = hi_q;
   assign out_lo  = lo_q;
   assign dt_busy = busy_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: stimulus queues expected {hi,lo,busy} per edge,
// a monitor pops and compares after each edge and watches the hi/lo exclusion.
module tb_pwm_deadtime;

   logic       sys_clk = 1'b0;
   logic       rst_n;
   logic       pwm_in;
   logic       en;
   logic       dt_wr;
   logic [5:0] dead_time_in;
   logic       out_hi;
   logic       out_lo;
   logic       dt_busy;

   pwm_deadtime #(.DT_WIDTH(6)) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .pwm_in       (pwm_in),
      .en           (en),
      .dt_wr        (dt_wr),
      .dead_time_in (dead_time_in),
      .out_hi       (out_hi),
      .out_lo       (out_lo),
      .dt_busy      (dt_busy)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int         cyc;
      logic [2:0] v;
      int         tag;
   } exp_t;

   exp_t q[$];
   int   edge_n     = 0;
   int   tag_n      = 0;
   int   compared   = 0;
   int   mismatched = 0;

   // Monitor: expectations tagged with the edge after which they hold.
   always @(posedge sys_clk) begin
      exp_t e;
      edge_n = edge_n + 1;
      #1;
      while (q.size() > 0 && q[0].cyc <= edge_n) begin
         e = q.pop_front();
         compared = compared + 1;
         if ({out_hi, out_lo, dt_busy} !== e.v || e.cyc != edge_n) begin
            mismatched = mismatched + 1;
            $display("FAIL out step %0d edge %0d: got hi,lo,busy=%b required %b", e.tag, edge_n,
                     {out_hi, out_lo, dt_busy}, e.v);
         end
      end
      compared = compared + 1;
      if (out_hi & out_lo) begin
         mismatched = mismatched + 1;
         $display("FAIL overlap edge %0d: got hi=%b lo=%b required not both 1", edge_n, out_hi, out_lo);
      end
   end

   task automatic step(input logic p, input logic e, input logic w, input logic [5:0] d,
                       input logic h, input logic l, input logic b);
      pwm_in       = p;
      en           = e;
      dt_wr        = w;
      dead_time_in = d;
      q.push_back('{cyc: edge_n + 1, v: {h, l, b}, tag: tag_n});
      tag_n = tag_n + 1;
      @(negedge sys_clk);
   endtask

   task automatic run(input logic p, input logic e, input int n,
                      input logic h, input logic l, input logic b);
      for (int i = 0; i < n; i++) step(p, e, 1'b0, 6'd0, h, l, b);
   endtask

   initial begin
      rst_n = 1'b0; pwm_in = 1'b0; en = 1'b0; dt_wr = 1'b0; dead_time_in = '0;
      @(negedge sys_clk);
      run(0, 1, 2, 0, 0, 0);               // held in reset even with en
      rst_n = 1'b1;
      run(0, 0, 2, 0, 0, 0);

      // Reset dead time of 1 cycle
      run(0, 1, 2, 0, 1, 0);
      run(1, 1, 1, 0, 0, 1);
      run(1, 1, 2, 1, 0, 0);
      run(0, 1, 1, 0, 0, 1);
      run(0, 1, 1, 0, 1, 0);

      // Dead time 4, 20-cycle high pulse
      step(0, 1, 1, 6'd4, 0, 1, 0);
      run(0, 1, 2, 0, 1, 0);
      run(1, 1, 4, 0, 0, 1);
      run(1, 1, 16, 1, 0, 0);
      run(0, 1, 4, 0, 0, 1);
      run(0, 1, 3, 0, 1, 0);

      // Dead time 8: short high pulse and short low glitch are swallowed
      step(0, 1, 1, 6'd8, 0, 1, 0);
      run(1, 1, 3, 0, 0, 1);
      run(0, 1, 3, 0, 1, 0);
      run(1, 1, 8, 0, 0, 1);
      run(1, 1, 3, 1, 0, 0);
      run(0, 1, 3, 0, 0, 1);
      run(1, 1, 3, 1, 0, 0);

      // en drop, en raised with pwm high, en drop mid DT_RISE
      run(1, 0, 2, 0, 0, 0);
      run(1, 1, 3, 0, 0, 0);
      run(0, 1, 2, 0, 1, 0);
      run(1, 1, 2, 0, 0, 1);
      run(1, 0, 2, 0, 0, 0);
      run(0, 1, 2, 0, 1, 0);

      // Held strobe captures only the first value (3)
      step(0, 1, 1, 6'd3, 0, 1, 0);
      step(0, 1, 1, 6'd4, 0, 1, 0);
      step(0, 1, 1, 6'd5, 0, 1, 0);
      step(0, 1, 1, 6'd6, 0, 1, 0);
      step(0, 1, 1, 6'd7, 0, 1, 0);
      run(0, 1, 1, 0, 1, 0);
      run(1, 1, 3, 0, 0, 1);
      run(1, 1, 2, 1, 0, 0);
      // Zero is stored as one
      step(1, 1, 1, 6'd0, 1, 0, 0);
      run(1, 1, 1, 1, 0, 0);
      run(0, 1, 1, 0, 0, 1);
      run(0, 1, 2, 0, 1, 0);
      // Write on the same edge as a counter load: old value (1) is used
      step(1, 1, 1, 6'd5, 0, 0, 1);
      run(1, 1, 3, 1, 0, 0);
      run(0, 1, 5, 0, 0, 1);
      run(0, 1, 2, 0, 1, 0);

      // Async reset mid HI_ON
      run(1, 1, 5, 0, 0, 1);
      run(1, 1, 2, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      compared = compared + 1;
      if ({out_hi, out_lo, dt_busy} !== 3'b000) begin
         mismatched = mismatched + 1;
         $display("FAIL async_reset: got hi,lo,busy=%b required 000", {out_hi, out_lo, dt_busy});
      end
      @(negedge sys_clk);
      rst_n = 1'b1;
      run(1, 1, 2, 0, 0, 0);
      run(0, 1, 1, 0, 1, 0);
      run(1, 1, 1, 0, 0, 1);              // dead time back to 1 after reset
      run(1, 1, 2, 1, 0, 0);

      // Random run; the monitor checks hi/lo exclusion every edge
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
         en           = ($urandom_range(0, 60) != 0);
         dt_wr        = ($urandom_range(0, 25) == 0);
         dead_time_in = 6'($urandom_range(0, 12));
         @(negedge sys_clk);
      end
      en = 1'b0; dt_wr = 1'b0;
      repeat (3) @(negedge sys_clk);

      compared = compared + 1;
      if (q.size() != 0) begin
         mismatched = mismatched + 1;
         $display("FAIL queue_drain: got %0d pending required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
